// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a sprite frame from ROM into the framebuffer, skipping KEY_COLOR pixels
// and clipping at the edges. Define SPRITE_SCALE2_EN to write each source pixel as a 2x2 block.
module sprite_blitter #(
    parameter int                VBUF_W    = 320,
    parameter int                VBUF_H    = 240,
    parameter int                DATA_W    = 12,
    parameter logic [DATA_W-1:0] KEY_COLOR = 12'h0f0,
    parameter int                SRC_AW    = 18,
    parameter int                FB_AW     = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SRC_AW-1:0] src_base,
    input  logic [8:0]        spr_w,
    input  logic [7:0]        spr_h,
    input  logic [8:0]        dst_x,
    input  logic [7:0]        dst_y,
    input  logic              mirror,
    output logic              busy,
    output logic              done,
    output logic [SRC_AW-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [DATA_W-1:0] fb_data,
    output logic              fb_we
);
`ifdef SPRITE_SCALE2_EN
    localparam int SC = 1;
`else
    localparam int SC = 0;
`endif
    localparam int CW = 9 + SC;
    localparam int RW = 8 + SC;
    localparam logic [CW:0] XLIM = (CW+1)'(VBUF_W);
    localparam logic [RW:0] YLIM = (RW+1)'(VBUF_H);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN0, S_DRAIN1, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [SRC_AW-1:0] base_q, base_d, acc_q, acc_d;
    logic [8:0]        w_q, w_d, x0_q, x0_d;
    logic [7:0]        h_q, h_d, y0_q, y0_d;
    logic              mir_q, mir_d;
    logic [CW-1:0]     col_q, col_d, lim_c;
    logic [RW-1:0]     row_q, row_d, lim_r;
    logic              v2_q, v2_d, done_q, done_d, we_q, we_d;
    logic [FB_AW-1:0]  fa2_q, fa2_d, fa_q, fa_d;
    logic [DATA_W-1:0] fd_q, fd_d;
    logic [8:0]        scol_src, scol;
    logic              row_step, last, in1;
    logic [CW:0]       dx;
    logic [RW:0]       dy;

`ifdef SPRITE_SCALE2_EN
    // Doubled iteration: source row advances every second destination row.
    assign lim_c    = {w_q, 1'b0} - 10'd1;
    assign lim_r    = {h_q, 1'b0} - 9'd1;
    assign scol_src = col_q[CW-1:1];
    assign row_step = row_q[0];
`else
    assign lim_c    = w_q - 9'd1;
    assign lim_r    = h_q - 8'd1;
    assign scol_src = col_q;
    assign row_step = 1'b1;
`endif

    assign scol     = mir_q ? w_q - 9'd1 - scol_src : scol_src;
    assign src_addr = base_q + acc_q + SRC_AW'(scol);
    // One extra bit so clipped coordinates cannot wrap back on screen.
    assign dx       = (CW+1)'(x0_q) + (CW+1)'(col_q);
    assign dy       = (RW+1)'(y0_q) + (RW+1)'(row_q);
    assign in1      = (dx < XLIM) && (dy < YLIM);
    assign last     = (col_q == lim_c) && (row_q == lim_r);
    assign busy     = state_q != S_IDLE;
    assign done     = done_q;
    assign fb_we    = we_q;
    assign fb_addr  = fa_q;
    assign fb_data  = fd_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        w_d     = w_q;
        h_d     = h_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        mir_d   = mir_q;
        col_d   = col_q;
        row_d   = row_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: if (start) begin
                base_d  = src_base;
                w_d     = spr_w;
                h_d     = spr_h;
                x0_d    = dst_x;
                y0_d    = dst_y;
                mir_d   = mirror;
                col_d   = '0;
                row_d   = '0;
                acc_d   = '0;
                state_d = (spr_w == 9'd0 || spr_h == 8'd0) ? S_DONE : S_RUN;
            end
            S_RUN: if (last) begin
                state_d = S_DRAIN0;
            end else if (col_q == lim_c) begin
                col_d = '0;
                row_d = row_q + 1'b1;
                acc_d = row_step ? acc_q + SRC_AW'(w_q) : acc_q;
            end else begin
                col_d = col_q + 1'b1;
            end
            S_DRAIN0: state_d = S_DRAIN1;
            S_DRAIN1: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
        v2_d   = (state_q == S_RUN) && in1;
        fa2_d  = FB_AW'(dy) * FB_AW'(VBUF_W) + FB_AW'(dx);
        we_d   = v2_q && (src_data != KEY_COLOR);
        fa_d   = v2_q ? fa2_q : fa_q;
        fd_d   = v2_q ? src_data : fd_q;
        done_d = state_q == S_DONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            w_q     <= '0;
            h_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            mir_q   <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            acc_q   <= '0;
            v2_q    <= 1'b0;
            fa2_q   <= '0;
            we_q    <= 1'b0;
            fa_q    <= '0;
            fd_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            mir_q   <= mir_d;
            col_q   <= col_d;
            row_q   <= row_d;
            acc_q   <= acc_d;
            v2_q    <= v2_d;
            fa2_q   <= fa2_d;
            we_q    <= we_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: directed checks of sprite_blitter write stream, clipping, keying and timing.
module tb_sprite_blitter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [17:0] src_base;
    logic [8:0]  spr_w;
    logic [7:0]  spr_h;
    logic [8:0]  dst_x;
    logic [7:0]  dst_y;
    logic        mirror;
    logic        busy, done, fb_we;
    logic [17:0] src_addr;
    logic [11:0] src_data;
    logic [16:0] fb_addr;
    logic [11:0] fb_data;

    logic [11:0] rom [0:63];
    int          wa[$];
    int          wd[$];
    int          checks = 0;
    int          errors = 0;
    int          dc, bz, hit, ndone;

    sprite_blitter dut (
        .clk(clk), .reset_n(reset_n), .start(start), .src_base(src_base),
        .spr_w(spr_w), .spr_h(spr_h), .dst_x(dst_x), .dst_y(dst_y), .mirror(mirror),
        .busy(busy), .done(done), .src_addr(src_addr), .src_data(src_data),
        .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we)
    );

    always #5 clk = ~clk;

    always @(posedge clk) src_data <= rom[src_addr[5:0]];

    always @(negedge clk) if (fb_we === 1'b1) begin
        wa.push_back(int'(fb_addr));
        wd.push_back(int'(fb_data));
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starts a blit and waits for done; a second start is injected at cycle inj (0 = none).
    task automatic blit(input int b, input int w, input int h, input int x, input int y,
                        input logic m, input int inj, output int dcyc, output int busy_at_done);
        wa.delete();
        wd.delete();
        dcyc = -1;
        busy_at_done = -1;
        @(negedge clk);
        src_base = 18'(b); spr_w = 9'(w); spr_h = 8'(h);
        dst_x = 9'(x); dst_y = 8'(y); mirror = m; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (c == inj) begin
                start = 1'b1; src_base = 18'd40; spr_w = 9'd1; spr_h = 8'd1; dst_x = 9'd0; dst_y = 8'd0;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                dcyc = c;
                busy_at_done = int'(busy);
                break;
            end
        end
    endtask

    task automatic check_plain(input string tag, input logic m);
        check({tag, "_count"}, wa.size(), 8);
        for (int i = 0; i < 8 && i < wa.size(); i++) begin
            check({tag, "_addr"}, wa[i], 1610 + (i / 4) * 320 + i % 4);
            check({tag, "_data"}, wd[i], m ? (i / 4) * 4 + (3 - i % 4) + 1 : i + 1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 12'(i + 1);
        reset_n = 1'b0; start = 1'b0; src_base = '0; spr_w = '0; spr_h = '0;
        dst_x = '0; dst_y = '0; mirror = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_we", int'(fb_we), 0);
        check("rst_src_addr", int'(src_addr), 0);
        check("rst_fb_addr", int'(fb_addr), 0);
        check("rst_fb_data", int'(fb_data), 0);
        @(negedge clk) reset_n = 1'b1;
`ifdef SPRITE_SCALE2_EN
        rom[0] = 12'h0a5; rom[1] = 12'h05b;
        blit(0, 2, 1, 0, 0, 1'b0, 0, dc, bz);
        check("s2_done_cycle", dc, 11);
        check("s2_count", wa.size(), 8);
        if (wa.size() == 8) begin
            check("s2_a0", wa[0], 0);   check("s2_d0", wd[0], 12'h0a5);
            check("s2_a1", wa[1], 1);   check("s2_d1", wd[1], 12'h0a5);
            check("s2_a2", wa[2], 2);   check("s2_d2", wd[2], 12'h05b);
            check("s2_a3", wa[3], 3);   check("s2_d3", wd[3], 12'h05b);
            check("s2_a4", wa[4], 320); check("s2_d4", wd[4], 12'h0a5);
            check("s2_a5", wa[5], 321); check("s2_d5", wd[5], 12'h0a5);
            check("s2_a6", wa[6], 322); check("s2_d6", wd[6], 12'h05b);
            check("s2_a7", wa[7], 323); check("s2_d7", wd[7], 12'h05b);
        end
`else
        blit(0, 4, 2, 10, 5, 1'b0, 0, dc, bz);
        check("t1_done_cycle", dc, 11);
        check("t1_busy_at_done", bz, 0);
        check_plain("t1", 1'b0);

        blit(0, 4, 2, 10, 5, 1'b1, 0, dc, bz);
        check("t2_done_cycle", dc, 11);
        check_plain("t2", 1'b1);

        rom[2] = 12'h0f0;
        blit(0, 4, 2, 10, 5, 1'b0, 0, dc, bz);
        rom[2] = 12'd3;
        check("t3_done_cycle", dc, 11);
        check("t3_count", wa.size(), 7);
        hit = 0;
        foreach (wa[i]) if (wa[i] == 1612) hit++;
        check("t3_key_skipped", hit, 0);

        blit(0, 4, 2, 318, 239, 1'b0, 0, dc, bz);
        check("t4_done_cycle", dc, 11);
        check("t4_count", wa.size(), 2);
        if (wa.size() == 2) begin
            check("t4_a0", wa[0], 76798); check("t4_d0", wd[0], 1);
            check("t4_a1", wa[1], 76799); check("t4_d1", wd[1], 2);
        end

        blit(0, 0, 2, 10, 5, 1'b0, 0, dc, bz);
        check("t5_zero_done_cycle", dc, 1);
        check("t5_zero_count", wa.size(), 0);

        blit(0, 4, 2, 10, 5, 1'b0, 3, dc, bz);
        check("t5_ign_done_cycle", dc, 11);
        check_plain("t5_ign", 1'b0);
        repeat (3) @(posedge clk);
        #1 check("t5_ign_idle", int'(busy), 0);

        wa.delete();
        @(negedge clk);
        src_base = '0; spr_w = 9'd4; spr_h = 8'd2; dst_x = 9'd10; dst_y = 8'd5; mirror = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("t5_we_before_rst", int'(fb_we), 1);
        #2 reset_n = 1'b0;
        #1;
        check("t5_we_async_drop", int'(fb_we), 0);
        check("t5_busy_rst", int'(busy), 0);
        @(negedge clk) reset_n = 1'b1;
        ndone = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done === 1'b1) ndone++;
        end
        check("t5_no_done_after_rst", ndone, 0);

        blit(0, 4, 2, 10, 5, 1'b0, 0, dc, bz);
        check("t5_rerun_done_cycle", dc, 11);
        check_plain("t5_rerun", 1'b0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
